// File: rtl/spi_apb_master.sv
// Single-outstanding APB requester: takes one read/write command, runs SETUP/ACCESS
// with a bounded wait on PREADY, and returns data/status on a valid/ready response port.
module spi_apb_master #(
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLE  = 6
) (
  input  logic                      apb_clk_in,
  input  logic                      apb_rst_in,
  input  logic                      cmd_valid_in,
  output logic                      cmd_ready_out,
  input  logic                      cmd_write_in,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_in,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata_in,
  output logic                      rsp_valid_out,
  input  logic                      rsp_ready_in,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_out,
  output logic                      rsp_err_out,
  output logic                      rsp_timeout_out,
  output logic [APB_ADDR_WIDTH-1:0] apb_addr_out,
  output logic                      apb_psel_out,
  output logic                      apb_penable_out,
  output logic                      apb_write_out,
  output logic [APB_DATA_WIDTH-1:0] apb_wdata_out,
  input  logic [APB_DATA_WIDTH-1:0] apb_rdata_in,
  input  logic                      apb_ready_in,
  input  logic                      apb_slverr_in
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]          cnt_q;
  logic [APB_ADDR_WIDTH-1:0] addr_q;
  logic                      write_q;
  logic [APB_DATA_WIDTH-1:0] wdata_q;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q;
  logic                      rsp_err_q;
  logic                      rsp_timeout_q;

  logic accept;
  logic done_ok;
  logic done_to;
  logic timeout_hit;

  assign timeout_hit = (cnt_q == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge apb_clk_in) begin
    if (apb_rst_in) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done_ok = 1'b0;
    done_to = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid_in) begin
          accept  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: state_d = S_ACCESS;
      S_ACCESS: begin
        if (apb_ready_in) begin
          done_ok = 1'b1;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          done_to = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_in) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: a synchronous reset clears every datapath register here; they are few
  // and all visible on ports, so nothing is left uninitialised after reset.
  always_ff @(posedge apb_clk_in) begin
    if (apb_rst_in) begin
      cnt_q         <= '0;
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= cmd_addr_in;
        write_q <= cmd_write_in;
        wdata_q <= cmd_write_in ? cmd_wdata_in : '0;
      end

      // Counter saturates at the abort point, so it never wraps.
      if (state_q == S_SETUP) begin
        cnt_q <= '0;
      end else if (state_q == S_ACCESS && !apb_ready_in && !timeout_hit) begin
        cnt_q <= cnt_q + CNT_ONE;
      end

      if (done_ok) begin
        rsp_rdata_q   <= (!write_q && !apb_slverr_in) ? apb_rdata_in : '0;
        rsp_err_q     <= apb_slverr_in;
        rsp_timeout_q <= 1'b0;
      end else if (done_to) begin
        rsp_rdata_q   <= '0;
        rsp_err_q     <= 1'b1;
        rsp_timeout_q <= 1'b1;
      end
    end
  end

  // Ready is masked during reset so nothing looks acceptable while the block is held.
  assign cmd_ready_out   = (state_q == S_IDLE) && !apb_rst_in;
  assign apb_psel_out    = (state_q == S_SETUP) || (state_q == S_ACCESS);
  assign apb_penable_out = (state_q == S_ACCESS);
  assign apb_addr_out    = addr_q;
  assign apb_write_out   = write_q;
  assign apb_wdata_out   = wdata_q;
  assign rsp_valid_out   = (state_q == S_RESP);
  assign rsp_rdata_out   = rsp_rdata_q;
  assign rsp_err_out     = rsp_err_q;
  assign rsp_timeout_out = rsp_timeout_q;

endmodule

// File: tb/tb_spi_apb_master.sv
// Bench for spi_apb_master: directed and random APB transfers compared against a
// transfer-level model of latency, PENABLE length, response data and status.
module tb_spi_apb_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int T  = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic [AW-1:0] apb_addr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          err;
    logic          timeout;
    int unsigned   pen;
    int unsigned   sel;
    int unsigned   lat;
    logic          ok;
  } obs_t;

  spi_apb_master #(
    .APB_DATA_WIDTH(DW),
    .APB_ADDR_WIDTH(AW),
    .TIMEOUT_CYCLE (T)
  ) dut (
    .apb_clk_in     (clk),
    .apb_rst_in     (rst),
    .cmd_valid_in   (cmd_valid),
    .cmd_ready_out  (cmd_ready),
    .cmd_write_in   (cmd_write),
    .cmd_addr_in    (cmd_addr),
    .cmd_wdata_in   (cmd_wdata),
    .rsp_valid_out  (rsp_valid),
    .rsp_ready_in   (rsp_ready),
    .rsp_rdata_out  (rsp_rdata),
    .rsp_err_out    (rsp_err),
    .rsp_timeout_out(rsp_timeout),
    .apb_addr_out   (apb_addr),
    .apb_psel_out   (psel),
    .apb_penable_out(penable),
    .apb_write_out  (pwrite),
    .apb_wdata_out  (pwdata),
    .apb_rdata_in   (prdata),
    .apb_ready_in   (pready),
    .apb_slverr_in  (pslverr)
  );

  always #5 clk = ~clk;

  // Transfer-level expectation: 'w' is the number of low PREADY samples before the
  // slave answers; w >= T means the slave never answers in time.
  function automatic obs_t model_xfer(input logic wr, input int w, input logic serr,
                                      input logic [DW-1:0] prd);
    obs_t e;
    int unsigned p;
    p         = (w < T) ? w + 1 : T;
    e.timeout = (w >= T);
    e.err     = e.timeout || serr;
    e.rdata   = (!wr && !e.err) ? prd : '0;
    e.pen     = p;
    e.sel     = p + 1;
    e.lat     = p + 2;
    e.ok      = 1'b1;
    return e;
  endfunction

  function automatic string obs_str(input obs_t o);
    return $sformatf("rdata=%h err=%b to=%b pen=%0d sel=%0d lat=%0d ok=%b",
                     o.rdata, o.err, o.timeout, o.pen, o.sel, o.lat, o.ok);
  endfunction

  // Drives one command, plays the APB slave, applies 'hold' cycles of response
  // backpressure (offering a competing command meanwhile) and records what was seen.
  task automatic run_xfer(input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input int w, input logic serr,
                          input logic [DW-1:0] prd, input int hold, output obs_t o);
    logic [DW-1:0] exp_wd;
    logic [DW-1:0] r_rdata;
    logic          r_err, r_to;
    int            acc;
    bit            done;
    o      = '0;
    o.ok   = 1'b1;
    exp_wd = wr ? wdata : '0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    if (cmd_ready !== 1'b1) o.ok = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_write = ~wr;
    acc  = 0;
    done = 0;
    o.lat = 1;
    for (int c = 0; c < 40 && !done; c++) begin
      if (rsp_valid === 1'b1) begin
        done = 1;
      end else begin
        if (psel === 1'b1) o.sel++;
        if (penable === 1'b1) o.pen++;
        if (psel === 1'b1 && (apb_addr !== addr || pwrite !== wr || pwdata !== exp_wd))
          o.ok = 1'b0;
        if (penable === 1'b1) begin
          pready  = (acc == w);
          pslverr = pready ? serr : 1'($urandom);
          prdata  = pready ? prd : $urandom;
          acc++;
        end else begin
          pready  = 1'b0;
          pslverr = 1'($urandom);
          prdata  = $urandom;
        end
        @(negedge clk);
        o.lat++;
      end
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    if (!done) o.lat = 999;
    r_rdata   = rsp_rdata;
    r_err     = rsp_err;
    r_to      = rsp_timeout;
    o.rdata   = r_rdata;
    o.err     = r_err;
    o.timeout = r_to;
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;
      cmd_addr  = $urandom;
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== r_rdata || rsp_err !== r_err ||
          rsp_timeout !== r_to || cmd_ready !== 1'b0 || psel !== 1'b0)
        o.ok = 1'b0;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || psel !== 1'b0) o.ok = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'hA030_0000;
    cmd_wdata = 32'h5555_AAAA;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({psel, penable, rsp_valid} !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold: psel/penable/rsp_valid=%b want 000", {psel, penable, rsp_valid});
      end
    end
    rst       = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: cmd_ready=%b want 1", cmd_ready);
    end
    checks++;
    if ({psel, penable, rsp_valid, rsp_err, rsp_timeout, rsp_rdata, apb_addr, pwrite, pwdata}
        !== '0) begin
      errors++;
      $display("FAIL reset_outputs: psel=%b pen=%b rv=%b err=%b to=%b rd=%h addr=%h wr=%b wd=%h want all 0",
               psel, penable, rsp_valid, rsp_err, rsp_timeout, rsp_rdata, apb_addr, pwrite, pwdata);
    end
  endtask

  task automatic test_zero_wait_write();
    obs_t o, e;
    run_xfer(1'b1, 32'hA030_0004, 32'h1234_5678, 0, 1'b0, 32'hFFFF_FFFF, 0, o);
    e = model_xfer(1'b1, 0, 1'b0, 32'hFFFF_FFFF);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL zero_wait_write: got %s want %s", obs_str(o), obs_str(e));
    end
  endtask

  task automatic test_wait_read();
    obs_t o, e;
    run_xfer(1'b0, 32'hA030_0008, 32'h0BAD_F00D, 3, 1'b0, 32'hDEAD_BEEF, 0, o);
    e = model_xfer(1'b0, 3, 1'b0, 32'hDEAD_BEEF);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL wait_read: got %s want %s", obs_str(o), obs_str(e));
    end
  endtask

  task automatic test_slverr();
    obs_t o, e;
    run_xfer(1'b0, 32'hA030_000C, 32'h0, 0, 1'b1, 32'hCAFE_F00D, 0, o);
    e = model_xfer(1'b0, 0, 1'b1, 32'hCAFE_F00D);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL slverr: got %s want %s", obs_str(o), obs_str(e));
    end
  endtask

  task automatic test_timeout();
    obs_t o, e;
    run_xfer(1'b0, 32'hA030_0010, 32'h0, 1000, 1'b0, 32'h1111_2222, 0, o);
    e = model_xfer(1'b0, 1000, 1'b0, 32'h1111_2222);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL timeout_abort: got %s want %s", obs_str(o), obs_str(e));
    end
    run_xfer(1'b0, 32'hA030_0014, 32'h0, T - 1, 1'b0, 32'h3333_4444, 0, o);
    e = model_xfer(1'b0, T - 1, 1'b0, 32'h3333_4444);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL timeout_last_sample: got %s want %s", obs_str(o), obs_str(e));
    end
  endtask

  task automatic test_backpressure();
    obs_t o, e;
    run_xfer(1'b0, 32'hA030_0018, 32'h0, 1, 1'b0, 32'h7654_3210, 5, o);
    e = model_xfer(1'b0, 1, 1'b0, 32'h7654_3210);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL backpressure: got %s want %s", obs_str(o), obs_str(e));
    end
  endtask

  task automatic test_mid_reset();
    bit   saw_rsp = 0;
    obs_t o, e;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'hA030_0020;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({psel, penable} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_drop: psel/penable=%b want 00", {psel, penable});
    end
    rst = 1'b0;
    pready = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) saw_rsp = 1;
    end
    pready = 1'b0;
    checks++;
    if (saw_rsp || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_no_rsp: saw_rsp=%0d cmd_ready=%b want 0/1", saw_rsp, cmd_ready);
    end
    run_xfer(1'b0, 32'hA030_0024, 32'h0, 2, 1'b0, 32'h0F0F_0F0F, 1, o);
    e = model_xfer(1'b0, 2, 1'b0, 32'h0F0F_0F0F);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL mid_reset_recover: got %s want %s", obs_str(o), obs_str(e));
    end
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    logic          wr, serr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd, prd;
    int            w, hold;
    for (int i = 0; i < 24; i++) begin
      wr   = 1'($urandom);
      serr = ($urandom_range(0, 3) == 0);
      addr = $urandom;
      wd   = $urandom;
      prd  = $urandom;
      w    = $urandom_range(0, T + 2);
      hold = $urandom_range(0, 3);
      run_xfer(wr, addr, wd, w, serr, prd, hold, o);
      e = model_xfer(wr, w, serr, prd);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back[%0d] wr=%b w=%0d: got %s want %s", i, wr, w, obs_str(o), obs_str(e));
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;
    test_reset();
    test_zero_wait_write();
    test_wait_read();
    test_slverr();
    test_timeout();
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_apb_master.md
Name: spi_apb_master

Overview:
- APB requester that drives the SPI register block's APB slave port, from bring-up benches and from an internal controller (boot loader / DMA sequencer).
- Accepts single read/write commands on a valid/ready command port and runs the APB SETUP and ACCESS phases.
- Waits for PREADY with a bounded timeout, then returns read data and error status on a valid/ready response port.
- One transfer outstanding at a time; no pipelining across transfers.

Parameters:
- APB_DATA_WIDTH, 32, width of PWDATA/PRDATA and command/response data.
- APB_ADDR_WIDTH, 32, width of PADDR and command address.
- TIMEOUT_CYCLE, 6, max ACCESS-phase cycles waiting for PREADY before abort; legal range >= 1.

Ports:
- apb_clk_in  input  1  single clock; all logic on rising edge.
- apb_rst_in  input  1  synchronous, active-high reset.
- cmd_valid_in  input  1  command present.
- cmd_ready_out  output  1  command accepted when high with cmd_valid_in.
- cmd_write_in  input  1  1 = write, 0 = read.
- cmd_addr_in  input  APB_ADDR_WIDTH  target address.
- cmd_wdata_in  input  APB_DATA_WIDTH  write data (ignored for reads).
- rsp_valid_out  output  1  response present.
- rsp_ready_in  input  1  response consumed.
- rsp_rdata_out  output  APB_DATA_WIDTH  read data; 0 for writes, errors and timeouts.
- rsp_err_out  output  1  PSLVERR seen or timeout.
- rsp_timeout_out  output  1  transfer aborted by timeout.
- apb_addr_out  output  APB_ADDR_WIDTH  PADDR.
- apb_psel_out  output  1  PSEL.
- apb_penable_out  output  1  PENABLE.
- apb_write_out  output  1  PWRITE.
- apb_wdata_out  output  APB_DATA_WIDTH  PWDATA.
- apb_rdata_in  input  APB_DATA_WIDTH  PRDATA.
- apb_ready_in  input  1  PREADY.
- apb_slverr_in  input  1  PSLVERR.

Behaviour:
- States: IDLE, SETUP, ACCESS, RESP (one-hot or encoded, implementer's choice).
- Reset (sync, apb_rst_in=1 at an edge):
  - State returns to IDLE.
  - All outputs 0, except cmd_ready_out, which is 1 from the first cycle after reset releases.
  - Timeout counter cleared.
  - Reset mid-transfer drops PSEL/PENABLE on the next edge and produces no response.
- cmd_ready_out = 1 only in IDLE. A command is accepted at edge N when cmd_valid_in && cmd_ready_out.
- IDLE -> SETUP (after edge N):
  - psel=1, penable=0.
  - addr/write/wdata registered from the command; wdata is 0 for reads.
- SETUP -> ACCESS (after edge N+1):
  - penable=1, timeout counter=0.
- ACCESS, PREADY sampled each edge from N+2:
  - apb_ready_in=1: go to RESP. psel=0, penable=0, rsp_valid_out=1.
  - rsp_rdata_out = apb_rdata_in for error-free reads, otherwise 0.
  - rsp_err_out = apb_slverr_in; rsp_timeout_out = 0.
  - apb_ready_in=0: counter increments. When TIMEOUT_CYCLE consecutive samples are low (edges N+2 .. N+1+TIMEOUT_CYCLE), abort: psel=0, penable=0, go to RESP with rsp_err_out=1, rsp_timeout_out=1, rsp_rdata_out=0.
  - PREADY high on the final allowed sample completes normally (no timeout).
- apb_slverr_in is ignored whenever apb_ready_in=0.
- Minimum latency: rsp_valid_out high 3 cycles after the acceptance edge.
- apb_addr_out, apb_write_out, apb_wdata_out are stable from SETUP through ACCESS, and hold their last values after the transfer.
- RESP:
  - rsp_valid_out and all rsp_* outputs are held stable until rsp_ready_in=1 at an edge.
  - Then go to IDLE and clear rsp_valid_out.
  - Response is not combinationally dependent on rsp_ready_in.
- Back-to-back commands take at least 1 IDLE cycle between transfers, so PSEL is low for at least 2 cycles between transfers.
- Counter width: clog2(TIMEOUT_CYCLE+1); it never wraps.

Test Plan:
- Reset then idle: assert apb_rst_in for 2 cycles with cmd_valid_in=1 -> psel/penable/rsp_valid stay 0 during reset; cmd_ready_out=1 on the first cycle after release.
- Zero-wait write: addr=0xA0300004, wdata=0x12345678, PREADY tied 1 -> psel high 2 cycles, penable high 1 cycle, PWDATA=0x12345678 and PWRITE=1 throughout; rsp_valid at N+3 with rsp_err=0, rsp_rdata=0.
- Wait-state read: addr=0xA0300008, PREADY low for 3 ACCESS cycles then high with PRDATA=0xDEADBEEF -> penable high 4 cycles; rsp_rdata=0xDEADBEEF, err=0, timeout=0.
- Slave error: read with PREADY=1 and PSLVERR=1 in the first ACCESS cycle -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Timeout: TIMEOUT_CYCLE=6, PREADY held 0 -> penable high exactly 6 cycles, then psel/penable drop; rsp_err=1, rsp_timeout=1. Repeat with PREADY=1 on the 6th ACCESS cycle -> normal completion.
- Backpressure and mid-transfer reset: hold rsp_ready_in=0 for 5 cycles -> rsp_* stable, cmd_ready=0, second command not accepted. Assert reset during ACCESS -> psel=0 next cycle and no response is issued.
